// File: rtl/fetch_pkg.sv
// Shared types, constants and the PC legality helper for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD,
        FAULT
    } fetch_state_e;

    // A PC is legal when word-aligned and no higher than the last word address.
    function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] mem_bytes);
        return (pc[1:0] == 2'b00) && (pc <= (mem_bytes - 32'(WORD_BYTES)));
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched word, its address and the valid bit.
module if_id_reg #(
    parameter logic [31:0] FLUSH_WORD = fetch_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);
    import fetch_pkg::*;

    // Flush wins over load so a redirect always discards the wrong-path word.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            instr    <= FLUSH_WORD;
            pc       <= 32'h0;
            pc_plus4 <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= FLUSH_WORD;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= instr_in;
            pc       <= pc_in;
            pc_plus4 <= pc_in + 32'(WORD_BYTES);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, sequences fetches into the IF/ID register,
// handles redirects and latches a sticky fault on illegal PC values.
module instr_fetch_unit #(
    parameter int unsigned MEM_BYTES = 64,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = fetch_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fault,
    output logic [31:0] fault_pc
);
    import fetch_pkg::*;

    // state | meaning
    // BOOT  | one idle cycle after reset, checks RESET_PC
    // RUN   | fetching one word per accepted cycle
    // HOLD  | decode stalled, PC and IF/ID frozen
    // FAULT | illegal PC seen, sticky until reset

    localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, pc_seq;
    logic         fault_d;
    logic [31:0]  fault_pc_d;
    logic         adv, load, flush;

    assign imem_pc = pc_q;
    assign adv     = !id_valid || id_ready;
    assign pc_seq  = pc_q + 32'(WORD_BYTES);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault;
        fault_pc_d = fault_pc;
        load       = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            BOOT: begin
                if (pc_legal(RESET_PC, MEM_BYTES_W)) begin
                    state_d = RUN;
                end else begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = RESET_PC;
                end
            end
            RUN, HOLD: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    state_d = RUN;
                    if (pc_legal(redirect_pc, MEM_BYTES_W)) begin
                        pc_d = redirect_pc;
                    end else begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_pc;
                    end
                end else if (adv) begin
                    // The current word is captured even when the next PC falls off the end.
                    load    = 1'b1;
                    state_d = RUN;
                    if (pc_legal(pc_seq, MEM_BYTES_W)) begin
                        pc_d = pc_seq;
                    end else begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_seq;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            FAULT: begin
                flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            fault    <= 1'b0;
            fault_pc <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fault    <= fault_d;
            fault_pc <= fault_pc_d;
        end
    end

    if_id_reg #(
        .FLUSH_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .flush    (flush),
        .instr_in (imem_instr),
        .pc_in    (pc_q),
        .valid    (id_valid),
        .instr    (id_instr),
        .pc       (id_pc),
        .pc_plus4 (id_pc_plus4)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: each driven cycle queues the expected
// post-edge outputs, and a monitor compares them after every rising edge.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        logic [31:0] imem;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        chk_pc;
        logic        f;
        logic [31:0] fpc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fault;
    logic [31:0] fault_pc;

    logic [31:0] mem [16];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        imem_instr = (imem_pc < 32'd64) ? mem[imem_pc[5:2]] : 32'hDEAD_BEEF;
    end

    instr_fetch_unit #(
        .MEM_BYTES (64),
        .RESET_PC  (32'h0),
        .NOP_WORD  (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    task automatic chk(input string name, input int cyc_no, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s (entry %0d): got %h want %h", name, cyc_no, act, want);
        end
    endtask

    // Monitor: compare the queued expectation after each rising edge.
    initial begin
        exp_t e;
        int   n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n++;
                chk("imem_pc",  n, imem_pc,          e.imem);
                chk("id_valid", n, 32'(id_valid),    32'(e.v));
                chk("id_instr", n, id_instr,         e.instr);
                chk("fault",    n, 32'(fault),       32'(e.f));
                chk("fault_pc", n, fault_pc,         e.fpc);
                if (e.chk_pc) begin
                    chk("id_pc",       n, id_pc,       e.pc);
                    chk("id_pc_plus4", n, id_pc_plus4, e.pc4);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic [31:0] e_imem, input logic e_v, input logic [31:0] e_instr,
                       input logic e_chk, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                       input logic e_f, input logic [31:0] e_fpc);
        exp_t e;
        @(negedge clk);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        e.imem   = e_imem;
        e.v      = e_v;
        e.instr  = e_instr;
        e.chk_pc = e_chk;
        e.pc     = e_pc;
        e.pc4    = e_pc4;
        e.f      = e_f;
        e.fpc    = e_fpc;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 32'h0000_0000;
        mem[1] = 32'h8C2B_000C;
        mem[2] = 32'h682B_1037;
        for (int k = 3; k < 16; k++) mem[k] = 32'hA000_0000 | 32'(k * 4);

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;

        // Sequential fetch from reset
        cyc(1,0,0,1,   32'h00, 0, NOP,          1, 32'h00, 32'h00, 0, 32'h00);
        cyc(1,0,0,1,   32'h00, 0, NOP,          1, 32'h00, 32'h00, 0, 32'h00);
        cyc(0,0,0,1,   32'h00, 0, NOP,          0, 32'h00, 32'h00, 0, 32'h00);
        cyc(0,0,0,1,   32'h04, 1, 32'h0000_0000,1, 32'h00, 32'h04, 0, 32'h00);
        cyc(0,0,0,1,   32'h08, 1, 32'h8C2B_000C,1, 32'h04, 32'h08, 0, 32'h00);
        // Backpressure while id_pc=4
        cyc(0,0,0,0,   32'h08, 1, 32'h8C2B_000C,1, 32'h04, 32'h08, 0, 32'h00);
        cyc(0,0,0,0,   32'h08, 1, 32'h8C2B_000C,1, 32'h04, 32'h08, 0, 32'h00);
        cyc(0,0,0,0,   32'h08, 1, 32'h8C2B_000C,1, 32'h04, 32'h08, 0, 32'h00);
        cyc(0,0,0,1,   32'h0C, 1, 32'h682B_1037,1, 32'h08, 32'h0C, 0, 32'h00);
        // Redirect to 0x20 with ready, then again with ready low
        cyc(0,1,32'h20,1, 32'h20, 0, NOP,        0, 32'h00, 32'h00, 0, 32'h00);
        cyc(0,0,0,1,   32'h24, 1, 32'hA000_0020,1, 32'h20, 32'h24, 0, 32'h00);
        cyc(0,1,32'h20,0, 32'h20, 0, NOP,        0, 32'h00, 32'h00, 0, 32'h00);
        cyc(0,0,0,1,   32'h24, 1, 32'hA000_0020,1, 32'h20, 32'h24, 0, 32'h00);
        // Misaligned redirect faults; later redirects are ignored
        cyc(0,1,32'h22,1, 32'h24, 0, NOP,        0, 32'h00, 32'h00, 1, 32'h22);
        cyc(0,1,32'h10,1, 32'h24, 0, NOP,        0, 32'h00, 32'h00, 1, 32'h22);
        cyc(0,0,0,1,   32'h24, 0, NOP,          0, 32'h00, 32'h00, 1, 32'h22);
        // Reset clears fault; fetch restarts at 0
        cyc(1,0,0,1,   32'h00, 0, NOP,          1, 32'h00, 32'h00, 0, 32'h00);
        cyc(0,0,0,1,   32'h00, 0, NOP,          0, 32'h00, 32'h00, 0, 32'h00);
        cyc(0,0,0,1,   32'h04, 1, 32'h0000_0000,1, 32'h00, 32'h04, 0, 32'h00);
        // Run off the end of memory
        cyc(0,1,32'h30,1, 32'h30, 0, NOP,        0, 32'h00, 32'h00, 0, 32'h00);
        cyc(0,0,0,1,   32'h34, 1, 32'hA000_0030,1, 32'h30, 32'h34, 0, 32'h00);
        cyc(0,0,0,1,   32'h38, 1, 32'hA000_0034,1, 32'h34, 32'h38, 0, 32'h00);
        cyc(0,0,0,1,   32'h3C, 1, 32'hA000_0038,1, 32'h38, 32'h3C, 0, 32'h00);
        cyc(0,0,0,1,   32'h3C, 1, 32'hA000_003C,1, 32'h3C, 32'h40, 1, 32'h40);
        cyc(0,0,0,1,   32'h3C, 0, NOP,          0, 32'h00, 32'h00, 1, 32'h40);
        // Reset while in HOLD with a concurrent redirect
        cyc(1,0,0,1,   32'h00, 0, NOP,          1, 32'h00, 32'h00, 0, 32'h00);
        cyc(0,0,0,1,   32'h00, 0, NOP,          0, 32'h00, 32'h00, 0, 32'h00);
        cyc(0,0,0,1,   32'h04, 1, 32'h0000_0000,1, 32'h00, 32'h04, 0, 32'h00);
        cyc(0,0,0,0,   32'h04, 1, 32'h0000_0000,1, 32'h00, 32'h04, 0, 32'h00);
        cyc(0,0,0,0,   32'h04, 1, 32'h0000_0000,1, 32'h00, 32'h04, 0, 32'h00);
        cyc(1,1,32'h20,0, 32'h00, 0, NOP,        1, 32'h00, 32'h00, 0, 32'h00);
        cyc(0,0,0,1,   32'h00, 0, NOP,          0, 32'h00, 32'h00, 0, 32'h00);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
